// File: rtl/uart_word_serializer_if.sv
// Handshake bundle between a 32-bit word producer, the word serializer and the
// byte-wide UART transmitter.
interface uart_word_serializer_if #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
);
    logic [WORD_W-1:0] iWord;
    logic              iWordValid;
    logic              oWordReady;
    logic [BYTE_W-1:0] oTxByte;
    logic              oTxStart;
    logic              iTxDone;
    logic              oWordDone;
    logic              oBusy;

    modport master (
        output iWord, iWordValid, iTxDone,
        input  oWordReady, oTxByte, oTxStart, oWordDone, oBusy
    );

    modport slave (
        input  iWord, iWordValid, iTxDone,
        output oWordReady, oTxByte, oTxStart, oWordDone, oBusy
    );
endinterface

// File: rtl/uart_word_serializer.sv
// Splits 32-bit words into bytes (MSB first) for the UART transmitter, with a
// one-word holding register so the next word can queue during serialization.
module uart_word_serializer #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    uart_word_serializer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] sh;
    logic              holdValid;
    logic [1:0]        cnt;
    logic              txStart;
    logic              wordDone;
    logic              accept;

    assign accept = bus.iWordValid && !holdValid;

    // Accept and load are mutually exclusive: accept needs holdValid low,
    // load needs it high, so both can safely live in one block.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state     <= IDLE;
            hold      <= '0;
            sh        <= '0;
            holdValid <= 1'b0;
            cnt       <= 2'd0;
            txStart   <= 1'b0;
            wordDone  <= 1'b0;
        end else begin
            txStart  <= 1'b0;
            wordDone <= 1'b0;
            if (accept) begin
                hold      <= bus.iWord;
                holdValid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (holdValid) begin
                        sh        <= hold;
                        holdValid <= 1'b0;
                        cnt       <= 2'd0;
                        state     <= START;
                        txStart   <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.iTxDone) begin
                        if (cnt == 2'd3) begin
                            state    <= IDLE;
                            wordDone <= 1'b1;
                        end else begin
                            sh      <= sh << BYTE_W;
                            cnt     <= cnt + 2'd1;
                            state   <= START;
                            txStart <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oWordReady = !holdValid;
    assign bus.oTxByte    = sh[WORD_W-1 -: BYTE_W];
    assign bus.oTxStart   = txStart;
    assign bus.oWordDone  = wordDone;
    assign bus.oBusy      = holdValid || (state != IDLE);
endmodule

// File: doc/uart_word_serializer.md
# uart_word_serializer

Transmit-side counterpart of the UART word packer: accepts 32-bit GPU words and drives them, one byte at a time, into the 8-bit UART transmitter. Bytes are sent MSB first (bits 31:24, then 23:16, 15:8, 7:0), so the receive-side packer on the host link reassembles the word unchanged. A one-word holding register lets the next word be accepted while the current one is still being serialized.

## Interface

Parameters:

- WORD_W, 32 (`GPU_WORD`), input word width; must be 4 × BYTE_W.
- BYTE_W, 8 (`UART_WORD_OUT_SZ`), UART byte width.

Ports:

- iClock  in  1  system clock; all state updates on the rising edge.
- iReset  in  1  reset, asynchronous, active-low; clears all state immediately.
- iWord  in  WORD_W  word to transmit; sampled on the accept edge.
- iWordValid  in  1  iWord is valid.
- oWordReady  out  1  holding register empty; a word is accepted on an edge where iWordValid & oWordReady.
- oTxByte  out  BYTE_W  byte to the UART transmitter.
- oTxStart  out  1  one-cycle request to the transmitter to send oTxByte.
- iTxDone  in  1  one-cycle pulse from the transmitter: current byte fully shifted out.
- oWordDone  out  1  one-cycle pulse: last byte of a word completed.
- oBusy  out  1  holding register full, or FSM not in IDLE.

## Operation

- Holding register `hold` / `hold_valid`.
  - oWordReady = !hold_valid.
  - Accept edge: hold <= iWord, hold_valid <= 1.
- Shift register `sh` (WORD_W bits), byte counter `cnt` (2 bits), FSM with states IDLE, START, WAIT:
  - IDLE: if hold_valid, then sh <= hold, hold_valid <= 0, cnt <= 0, go to START. Otherwise stay in IDLE.
  - START: oTxStart = 1 for exactly this cycle (Moore output). Unconditionally go to WAIT.
  - WAIT: on iTxDone:
    - If cnt == 3: oWordDone pulses next cycle; go to IDLE.
    - Else: sh <= sh << BYTE_W, cnt <= cnt + 1, go to START.
    - Without iTxDone: stay in WAIT.
- oTxByte = sh[WORD_W-1 -: BYTE_W]. It is held stable from START until the iTxDone that ends the byte.
- iTxDone is honored only in WAIT. It is ignored in IDLE and START, with no state change.
- Unused or illegal FSM encodings recover to IDLE.
- Accept and load can never occur on the same edge, because oWordReady is low while hold_valid is set. A new word may be accepted in any FSM state once `hold` has been emptied into `sh`.

## Timing

- Reset values:
  - oWordReady = 1.
  - oTxStart = 0.
  - oWordDone = 0.
  - oBusy = 0.
  - oTxByte = 0.
  - FSM = IDLE.
  - hold_valid = 0, cnt = 0.
- Latency with the FSM idle:
  - Word accepted at edge E0.
  - FSM loads at E1; oTxStart is high between E1 and E2.
  - oWordReady is low between E0 and E1, and high again after E1.
- Per byte: START (1 cycle), then WAIT until iTxDone. The next START comes in the cycle after the iTxDone edge. Minimum 2 cycles per byte when iTxDone arrives in the first WAIT cycle.
- Back-to-back words: WAIT (cnt=3) + iTxDone → IDLE (1 cycle) → START of the next word. One idle cycle between words; oWordDone is high in that IDLE cycle.
- oBusy falls in the IDLE cycle following the final iTxDone only if hold_valid = 0.
- Reset asserted mid-word:
  - All state clears asynchronously; the partial word is discarded.
  - A late iTxDone from the transmitter after release is ignored (FSM in IDLE).

## Test plan

- Single word: after reset, present iWord=0xDEADBEEF with iWordValid for 1 cycle; transmitter model returns iTxDone 10 cycles after each oTxStart. Required:
  - oTxByte = 0xDE, 0xAD, 0xBE, 0xEF in that order, with exactly 4 oTxStart pulses.
  - One oWordDone pulse, after which oBusy = 0.
- Back-to-back: hold iWordValid high with 0x01020304 then 0xA0B0C0D0. Required:
  - The second word is accepted the cycle after the first is loaded into `sh`.
  - 8 bytes 01 02 03 04 A0 B0 C0 D0 are sent, with exactly one IDLE cycle between words.
- Backpressure: keep iWordValid high with a third word while `hold` is full. Required: oWordReady stays 0 and the word is not accepted until the second word loads into `sh`; no word is lost or duplicated.
- Immediate done: iTxDone arrives in the first WAIT cycle of every byte. Required: one oTxStart every 2 cycles; a word completes in 8 cycles after load.
- Spurious done: pulse iTxDone in IDLE, and in the START cycle. Required: no state change, no extra bytes, cnt unchanged.
- Mid-word reset: assert iReset low after byte 0xAD of 0xDEADBEEF. Required:
  - All outputs return to their reset values asynchronously.
  - After release, a subsequent iTxDone is ignored, and a new word 0x11223344 transmits correctly starting at 0x11.
